// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one 16x16 signed*unsigned multiplier.
// Define MULT_ARBITER_CLIP_EN to saturate A to 16 bits instead of wrapping it.
module mult_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic               clk,
  input  logic               iRst,
  input  logic [NREQ-1:0]    iReq,
  input  logic [17*NREQ-1:0] iA,
  input  logic [16*NREQ-1:0] iB,
  output logic [NREQ-1:0]    oGrant,
  output logic               oValid,
  output logic [TAGW-1:0]    oTag,
  output logic [31:0]        oProduct,
  output logic [15:0]        oHigh
);

  logic [TAGW-1:0]    ptr;
  logic [TAGW-1:0]    ptr_nxt;
  logic [TAGW-1:0]    gtag;
  logic [NREQ-1:0]    pending;
  logic [NREQ-1:0]    elig;
  logic [NREQ-1:0]    clr;
  logic               found;
  logic [16:0]        a_sel;
  logic [15:0]        b_sel;
  logic [15:0]        a_sat;
  logic               s1_v;
  logic [TAGW-1:0]    s1_tag;
  logic [15:0]        s1_a;
  logic [15:0]        s1_b;
  logic signed [32:0] prod;

  assign elig  = iReq & ~pending;
  assign oHigh = oProduct[31:16];

  // round-robin search from ptr upward with wrap
  always_comb begin
    int j;
    logic [TAGW-1:0] idx;
    found  = 1'b0;
    gtag   = '0;
    oGrant = '0;
    j      = 0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      idx = TAGW'(j);
      if (!found && elig[idx]) begin
        found       = 1'b1;
        gtag        = idx;
        oGrant[idx] = 1'b1;
      end
    end
    if (iRst) begin
      found  = 1'b0;
      oGrant = '0;
    end
  end

  // one-hot AND-OR mux of the granted operands
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      a_sel = a_sel | (iA[17*k +: 17] & {17{oGrant[k]}});
      b_sel = b_sel | (iB[16*k +: 16] & {16{oGrant[k]}});
    end
  end

`ifdef MULT_ARBITER_CLIP_EN
  // saturate 17-bit signed A into the 16-bit signed range
  always_comb begin
    if ($signed(a_sel) > 17'sd32767)
      a_sat = 16'h7fff;
    else if ($signed(a_sel) < -17'sd32768)
      a_sat = 16'h8000;
    else
      a_sat = a_sel[15:0];
  end
`else
  logic unused_a;
  assign a_sat    = a_sel[15:0];
  assign unused_a = a_sel[16];
`endif

  // result-return clear mask and next round-robin pointer
  always_comb begin
    clr = '0;
    for (int k = 0; k < NREQ; k++)
      clr[k] = oValid && (oTag == TAGW'(k));
    if (gtag == TAGW'(NREQ-1))
      ptr_nxt = '0;
    else
      ptr_nxt = gtag + 1'b1;
  end

  // pointer and pending flags; clear wins over set
  always_ff @(posedge clk) begin
    if (iRst) begin
      ptr     <= '0;
      pending <= '0;
    end else begin
      pending <= (pending | oGrant) & ~clr;
      if (found) ptr <= ptr_nxt;
    end
  end

  // stage 1: capture granted operands and tag
  always_ff @(posedge clk) begin
    if (iRst) begin
      s1_v   <= 1'b0;
      s1_tag <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else begin
      s1_v <= found;
      if (found) begin
        s1_tag <= gtag;
        s1_a   <= a_sat;
        s1_b   <= b_sel;
      end
    end
  end

  logic unused_p;
  assign prod     = $signed(s1_a) * $signed({1'b0, s1_b});
  assign unused_p = prod[32];

  // stage 2: register product onto outputs, hold when idle
  always_ff @(posedge clk) begin
    if (iRst) begin
      oValid   <= 1'b0;
      oTag     <= '0;
      oProduct <= '0;
    end else begin
      oValid <= s1_v;
      if (s1_v) begin
        oTag     <= s1_tag;
        oProduct <= prod[31:0];
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: vector table plus scoreboard for mult_arbiter.
// Expected products are pushed at grant time and popped on oValid.
module tb_mult_arbiter;
  localparam int NREQ = 4;
  localparam int TAGW = 2;

  logic               clk = 1'b0;
  logic               iRst;
  logic [NREQ-1:0]    iReq;
  logic [17*NREQ-1:0] iA;
  logic [16*NREQ-1:0] iB;
  logic [NREQ-1:0]    oGrant;
  logic               oValid;
  logic [TAGW-1:0]    oTag;
  logic [31:0]        oProduct;
  logic [15:0]        oHigh;

  mult_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk(clk), .iRst(iRst), .iReq(iReq), .iA(iA), .iB(iB),
    .oGrant(oGrant), .oValid(oValid), .oTag(oTag),
    .oProduct(oProduct), .oHigh(oHigh)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAGW-1:0] tag;
    logic [31:0]     prod;
  } exp_t;

  typedef struct {
    logic [16:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  exp_t            sb[$];
  vec_t            tbl[8];
  logic [31:0]     cur_exp[NREQ];
  int              gcyc[NREQ];
  int              ngr[NREQ];
  int              nval[NREQ];
  logic [NREQ-1:0] gseq[$];
  int              gcq[$];
  logic [NREQ-1:0] last_gnt;
  bit              hold;
  int              cyc  = 0;
  int              nvec = 0;
  int              nerr = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] model(logic [16:0] a, logic [15:0] b);
    longint sa;
    logic signed [15:0] a16;
`ifdef MULT_ARBITER_CLIP_EN
    a16 = '0;
    sa  = longint'($signed(a));
    if (sa > 32767) sa = 32767;
    else if (sa < -32768) sa = -32768;
`else
    a16 = a[15:0];
    sa  = longint'(a16);
`endif
    return 32'(sa * longint'(b));
  endfunction

  task automatic clr_stats();
    sb.delete();
    for (int k = 0; k < NREQ; k++) begin
      ngr[k]  = 0;
      nval[k] = 0;
      gcyc[k] = 0;
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    last_gnt = oGrant;
    if (oGrant != '0) begin
      chk("onehot", 32'($countones(oGrant)), 32'd1);
      gseq.push_back(oGrant);
      gcq.push_back(cyc);
      for (int k = 0; k < NREQ; k++) begin
        if (oGrant[k]) begin
          chk("regrant", 32'(nval[k]), 32'(ngr[k]));
          ngr[k]++;
          gcyc[k] = cyc;
          e.tag  = TAGW'(k);
          e.prod = cur_exp[k];
          sb.push_back(e);
        end
      end
    end
    if (oValid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("tag", 32'(oTag), 32'(e.tag));
        chk("product", oProduct, e.prod);
        chk("high", 32'(oHigh), 32'(e.prod[31:16]));
        chk("latency", 32'(cyc - gcyc[e.tag]), 32'd2);
        nval[e.tag]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!hold) iReq = iReq & ~last_gnt;
  endtask

  task automatic load(int k, logic [16:0] a, logic [15:0] b,
                      logic [31:0] p);
    iA[17*k +: 17] = a;
    iB[16*k +: 16] = b;
    cur_exp[k]     = p;
    iReq[k]        = 1'b1;
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    iReq = '0;
    tick();
    iRst = 1'b0;
    clr_stats();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((iReq != '0 || sb.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    chk("drain", 32'(sb.size()) | 32'(iReq), 32'd0);
  endtask

  initial begin
    int n;
    iRst     = 1'b1;
    iReq     = '0;
    iA       = '0;
    iB       = '0;
    hold     = 1'b0;
    last_gnt = '0;
    clr_stats();

    tbl[0] = '{17'd1000,    16'd2,     32'd2000};
    tbl[1] = '{17'h1FFFE,   16'hFFFF,  32'hFFFE0002};
`ifdef MULT_ARBITER_CLIP_EN
    tbl[2] = '{17'd40000,   16'hFFFF,  32'h7FFE8001};
    tbl[5] = '{17'h10000,   16'd3,     32'hFFFE8000};
`else
    tbl[2] = '{17'd40000,   16'hFFFF,  32'h9C4063C0};
    tbl[5] = '{17'h10000,   16'd3,     32'h00000000};
`endif
    tbl[3] = '{17'h18000,   16'hFFFF,  32'h80008000};
    tbl[4] = '{17'd32767,   16'd1,     32'd32767};
    tbl[6] = '{17'd0,       16'd12345, 32'd0};
    tbl[7] = '{17'h1FFFF,   16'd40000, 32'hFFFF63C0};

    // reset state with requests asserted: grants must stay low
    iReq = '1;
    tick();
    chk("rst_grant", 32'(oGrant), 32'd0);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_tag", 32'(oTag), 32'd0);
    chk("rst_product", oProduct, 32'd0);
    chk("rst_high", 32'(oHigh), 32'd0);
    iReq = '0;
    iRst = 1'b0;
    clr_stats();

    // single request, exact latency
    load(0, 17'd1000, 16'd2, 32'd2000);
    n = 0;
    do begin
      tick();
      n++;
    end while (last_gnt == '0 && n < 6);
    chk("single_grant", 32'(last_gnt), 32'd1);
    chk("single_n1_valid", 32'(oValid), 32'd0);
    tick();
    chk("single_n2_valid", 32'(oValid), 32'd1);
    chk("single_n2_tag", 32'(oTag), 32'd0);
    chk("single_n2_prod", oProduct, 32'd2000);
    tick();
    chk("single_pulse", 32'(oValid), 32'd0);
    chk("single_hold", oProduct, 32'd2000);

    // table vectors one at a time, rotating requesters
    for (int i = 0; i < 8; i++) begin
      load(i % 4, tbl[i].a, tbl[i].b, tbl[i].p);
      drain();
      chk("tbl_pulse", 32'(oValid), 32'd0);
      chk("tbl_hold", oProduct, tbl[i].p);
      chk("tbl_hold_hi", 32'(oHigh), 32'(tbl[i].p >> 16));
    end

    // table vectors four at a time, back to back
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 4; k++)
        load(k, tbl[4*g+k].a, tbl[4*g+k].b, tbl[4*g+k].p);
      drain();
    end

    // fairness with continuous requests from ptr=0
    do_reset();
    gseq.delete();
    gcq.delete();
    hold = 1'b1;
    for (int k = 0; k < 4; k++)
      load(k, 17'(k*3000 - 4500), 16'(k*777 + 9),
           model(17'(k*3000 - 4500), 16'(k*777 + 9)));
    for (int i = 0; i < 12; i++) tick();
    hold = 1'b0;
    iReq = '0;
    drain();
    chk("fair_count", 32'(gseq.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < gseq.size(); i++) begin
      chk("fair_order", 32'(gseq[i]), 32'(1 << (i % 4)));
      chk("fair_b2b", 32'(gcq[i] - gcq[0]), 32'(i));
    end

    // reset mid-flight discards the in-flight result
    do_reset();
    load(2, 17'd300, 16'd5, 32'd1500);
    load(0, 17'd300, 16'd5, 32'd1500);
    n = 0;
    do begin
      tick();
      n++;
    end while (last_gnt == '0 && n < 6);
    chk("mid_grant", 32'(last_gnt), 32'd1);
    iRst = 1'b1;
    iReq = 4'b0110;
    #1;
    chk("mid_grant_forced", 32'(oGrant), 32'd0);
    chk("mid_n1_valid", 32'(oValid), 32'd0);
    clr_stats();
    tick();
    iRst = 1'b0;
    iReq = '0;
    for (int c = 2; c <= 4; c++) begin
      chk("mid_no_valid", 32'(oValid), 32'd0);
      tick();
    end
    for (int k = 0; k < 4; k++)
      load(k, 17'd7, 16'(k + 1), 32'(7 * (k + 1)));
    tick();
    chk("mid_ptr_pending", 32'(last_gnt), 32'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
